// File: rtl/pixel_dma_pkg.sv
// Shared definitions for the Wishbone pixel DMA master.
//   state_t    : control FSM encoding (IDLE, RUN, WAIT, DONE)
//   WB_SEL_ALL : byte-select value driven while a write cycle is active
//   ADR_STEP   : address increment between consecutive 32-bit writes
package pixel_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADR_STEP   = 32'd4;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with full/empty flags.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   flush      : synchronous clear of all entries
//   push/wdata : write request and data (ignored when full unless popping)
//   pop/rdata  : read request; rdata always shows the current head
//   full/empty : occupancy flags
// DEPTH must be a power of two (>= 2); pointers carry one extra wrap bit.
module sync_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_en = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same edge.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + PTR_ONE;
      if (rd_en) rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_pixel_dma.sv
// Wishbone classic write master that packs a pixel byte stream into
// big-endian 32-bit words and writes them to consecutive addresses.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, base_adr,
//   word_count            : transfer request (start sampled only when idle)
//   busy, done, err       : status (done is a 1-cycle pulse, err is sticky)
//   pix_valid, pix_data,
//   pix_ready             : byte stream input handshake
//   wb_*                  : Wishbone classic master write port
module wb_pixel_dma
  import pixel_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    T_ONE   = 1;
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      adr;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] words_packed;
  logic [1:0]       byte_idx;
  logic [23:0]      acc;
  logic [TW-1:0]    tcnt;
  logic             zero_done;

  logic             start_go;
  logic             zero_go;
  logic             issue;
  logic             ack_take;
  logic             abort;
  logic             accept;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_head;
  logic             unused_adr_bits;

  // Low address bits are forced to zero; keep them visibly consumed.
  assign unused_adr_bits = ^base_adr[1:0];

  assign busy      = (state == S_RUN) || (state == S_WAIT);
  assign done      = (state == S_DONE) || zero_done;
  assign wb_cyc_o  = (state == S_WAIT);
  assign wb_stb_o  = wb_cyc_o;
  assign wb_we_o   = wb_cyc_o;
  assign wb_sel_o  = wb_cyc_o ? WB_SEL_ALL : 4'h0;

  // Stop accepting once every word is packed, and hold the fourth byte of a
  // word until the FIFO has a slot for it.
  assign pix_ready = busy && (words_packed < total) && !((byte_idx == 2'd3) && fifo_full);
  assign accept    = pix_valid && pix_ready;
  assign fifo_push = accept && (byte_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    zero_go   = 1'b0;
    issue     = 1'b0;
    ack_take  = 1'b0;
    abort     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            start_go  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            zero_go = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!fifo_empty) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack on the final timeout cycle still completes the write.
        if (wb_ack_i) begin
          ack_take  = 1'b1;
          state_nxt = (remaining == CNT_ONE) ? S_DONE : S_RUN;
        end else if (tcnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr       <= '0;
      remaining <= '0;
      total     <= '0;
      tcnt      <= '0;
      zero_done <= 1'b0;
      err       <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
    end else begin
      zero_done <= zero_go;
      if (start_go) begin
        adr       <= {base_adr[31:2], 2'b00};
        remaining <= word_count;
        total     <= word_count;
      end
      if (start_go || zero_go) err <= 1'b0;
      else if (abort)          err <= 1'b1;
      if (issue) begin
        wb_adr_o <= adr;
        wb_dat_o <= fifo_head;
        tcnt     <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + T_ONE;
      end
      if (ack_take) begin
        adr       <= adr + ADR_STEP;
        remaining <= remaining - CNT_ONE;
      end
    end
  end

  // Packer control: byte position within the current word and words completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      words_packed <= '0;
    end else if (start_go || abort) begin
      byte_idx     <= 2'd0;
      words_packed <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      if (byte_idx == 2'd3) words_packed <= words_packed + CNT_ONE;
    end
  end

  // Earlier bytes shift toward the MSBs, so the first byte lands in [31:24].
  always_ff @(posedge clk) begin
    if (accept) acc <= {acc[15:0], pix_data};
  end

  sync_word_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start_go || abort),
    .push  (fifo_push),
    .wdata ({acc, pix_data}),
    .pop   (ack_take),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_wb_pixel_dma.sv
module tb_wb_pixel_dma;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_adr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic             pix_valid = 1'b0;
  logic [7:0]       pix_data = '0;
  logic             pix_ready;
  logic [31:0]      wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [3:0]       wb_sel_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  off_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  sent_q[$];
  logic [31:0] got_adr[$];
  logic [31:0] got_dat[$];
  logic [3:0]  got_sel[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];

  int done_cnt, cyc_cnt, ready_cnt, cur_run, max_run, stb_neq, stb_age;
  bit ack_en = 1'b0;
  bit dense = 1'b0;
  int ack_lat = 1;

  always #5 clk = ~clk;

  wb_pixel_dma #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (255),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_adr   (base_adr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i)
  );

  task automatic clear_log();
    sent_q.delete();
    got_adr.delete();
    got_dat.delete();
    got_sel.delete();
    done_cnt = 0; cyc_cnt = 0; ready_cnt = 0;
    cur_run = 0; max_run = 0; stb_neq = 0;
  endtask

  // Advance to the next falling edge, then set this cycle's inputs and log
  // the handshakes that the following rising edge will complete.
  task automatic tick();
    @(negedge clk);
    if (wb_cyc_o && wb_stb_o) stb_age++;
    else stb_age = 0;
    wb_ack_i = ack_en && wb_cyc_o && wb_stb_o && (stb_age > ack_lat);
    if (src_q.size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
      pix_valid = 1'b1;
      pix_data  = src_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
    end
    if (pix_valid && pix_ready) begin
      sent_q.push_back(pix_data);
      src_q.delete(0);
    end
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      got_adr.push_back(wb_adr_o);
      got_dat.push_back(wb_dat_o);
      got_sel.push_back(wb_sel_o);
    end
    if (done) done_cnt++;
    if (pix_ready) ready_cnt++;
    if (wb_stb_o !== wb_cyc_o) stb_neq++;
    if (wb_cyc_o) begin
      cyc_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input int n);
    start = 1'b1;
    base_adr = b;
    word_count = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic load_random(input int n);
    off_q.delete();
    for (int i = 0; i < n; i++) off_q.push_back(8'($urandom));
  endtask

  // Reference: word i goes to aligned base + 4*i (mod 2^32) and carries
  // offered bytes 4i..4i+3 with the earliest byte most significant.
  task automatic build_model(input logic [31:0] b, input int n);
    logic [31:0] a;
    exp_adr.delete();
    exp_dat.delete();
    a = {b[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(a + 32'(4 * i));
      exp_dat.push_back({off_q[4*i], off_q[4*i+1], off_q[4*i+2], off_q[4*i+3]});
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({busy, done, err, pix_ready, wb_cyc_o, wb_stb_o, wb_we_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy/done/err/rdy/cyc/stb/we=%b want 0000000",
               {busy, done, err, pix_ready, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    checks++;
    if (wb_sel_o !== 4'h0 || wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus sel=%h adr=%h dat=%h want 0/0/0", wb_sel_o, wb_adr_o, wb_dat_o);
    end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, done, err, pix_ready, wb_cyc_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release busy/done/err/rdy/cyc=%b want 00000",
               {busy, done, err, pix_ready, wb_cyc_o});
    end
  endtask

  task automatic test_transfer(input string name, input logic [31:0] b, input int n,
                               input int lat, input bit poke);
    int k;
    int want_acc;
    int bad;
    clear_log();
    src_q = off_q;
    ack_en = 1'b1;
    ack_lat = lat;
    want_acc = (off_q.size() < 4 * n) ? off_q.size() : 4 * n;
    pulse_start(b, n);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_start busy=%b err=%b want busy=1 err=0", name, busy, err);
    end
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      if (poke && k == 3) begin
        start = 1'b1; base_adr = ~b; word_count = '0;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      k++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_complete done not seen within %0d cycles, want a done pulse", name, k);
    end
    repeat (6) tick();
    build_model(b, n);
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_status done_pulses=%0d busy=%b err=%b want 1/0/0", name, done_cnt, busy, err);
    end
    checks++;
    if (got_adr.size() != exp_adr.size()) begin
      errors++;
      $display("FAIL %s_writes count=%0d want %0d", name, got_adr.size(), exp_adr.size());
    end
    for (int i = 0; i < exp_adr.size() && i < got_adr.size(); i++) begin
      checks++;
      if (got_adr[i] !== exp_adr[i] || got_dat[i] !== exp_dat[i] || got_sel[i] !== 4'hF) begin
        errors++;
        $display("FAIL %s_wr%0d adr=%h dat=%h sel=%h want adr=%h dat=%h sel=f",
                 name, i, got_adr[i], got_dat[i], got_sel[i], exp_adr[i], exp_dat[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < sent_q.size() && i < off_q.size(); i++)
      if (sent_q[i] !== off_q[i]) bad++;
    checks++;
    if (sent_q.size() != want_acc || bad != 0 || stb_neq != 0) begin
      errors++;
      $display("FAIL %s_bytes accepted=%0d bad=%0d stb_ne_cyc=%0d want %0d/0/0",
               name, sent_q.size(), bad, stb_neq, want_acc);
    end
  endtask

  task automatic test_basic();
    off_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    test_transfer("basic", 32'h0000_0100, 2, 1, 1'b0);
    checks++;
    if (got_dat.size() != 2 || got_dat[0] !== 32'h1122_3344 || got_adr[0] !== 32'h100) begin
      errors++;
      $display("FAIL basic_first writes=%0d first=%h@%h want 11223344@00000100",
               got_dat.size(), (got_dat.size() > 0) ? got_dat[0] : 32'h0,
               (got_adr.size() > 0) ? got_adr[0] : 32'h0);
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    load_random(8);
    src_q = off_q;
    pulse_start(32'h40, 0);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL zero_done_timing pulses=%0d want 1 on the cycle after start", done_cnt);
    end
    repeat (10) tick();
    checks++;
    if (done_cnt != 1 || cyc_cnt != 0 || ready_cnt != 0 || sent_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_count done=%0d cyc_cycles=%0d ready_cycles=%0d accepted=%0d busy=%b want 1/0/0/0/0",
               done_cnt, cyc_cnt, ready_cnt, sent_q.size(), busy);
    end
    src_q.delete();
  endtask

  task automatic test_backpressure();
    int k;
    clear_log();
    load_random(24);
    src_q = off_q;
    ack_en = 1'b0;
    pulse_start(32'h0000_2000, 6);
    repeat (60) tick();
    checks++;
    if (sent_q.size() != 19 || pix_ready !== 1'b0 || wb_cyc_o !== 1'b1 || got_adr.size() != 0) begin
      errors++;
      $display("FAIL bp_stall accepted=%0d ready=%b cyc=%b writes=%0d want 19/0/1/0",
               sent_q.size(), pix_ready, wb_cyc_o, got_adr.size());
    end
    ack_en = 1'b1;
    ack_lat = 0;
    k = 0;
    while (done_cnt == 0 && k < 500) begin tick(); k++; end
    repeat (4) tick();
    build_model(32'h0000_2000, 6);
    checks++;
    if (done_cnt != 1 || got_adr.size() != 6 || sent_q.size() != 24) begin
      errors++;
      $display("FAIL bp_release done=%0d writes=%0d accepted=%0d want 1/6/24",
               done_cnt, got_adr.size(), sent_q.size());
    end
    for (int i = 0; i < 6 && i < got_adr.size(); i++) begin
      checks++;
      if (got_adr[i] !== exp_adr[i] || got_dat[i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL bp_wr%0d adr=%h dat=%h want adr=%h dat=%h",
                 i, got_adr[i], got_dat[i], exp_adr[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_log();
    load_random(4);
    src_q = off_q;
    ack_en = 1'b0;
    pulse_start(32'h0000_0300, 1);
    k = 0;
    while (busy && k < 600) begin tick(); k++; end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || max_run != 255) begin
      errors++;
      $display("FAIL timeout_len busy=%b cyc_high_cycles=%0d want busy=0 and 255", busy, max_run);
    end
    checks++;
    if (err !== 1'b1 || done_cnt != 0 || got_adr.size() != 0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status err=%b done=%0d writes=%0d cyc=%b want 1/0/0/0",
               err, done_cnt, got_adr.size(), wb_cyc_o);
    end
    load_random(4);
    test_transfer("after_timeout", 32'h0000_0304, 1, 1, 1'b0);
  endtask

  task automatic test_wrap();
    load_random(8);
    test_transfer("wrap_one", 32'hFFFF_FFFC, 1, 1, 1'b0);
    load_random(10);
    test_transfer("wrap_two", 32'hFFFF_FFFF, 2, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int k;
    clear_log();
    load_random(8);
    src_q = off_q;
    ack_en = 1'b0;
    pulse_start(32'h0000_0500, 2);
    k = 0;
    while (!wb_cyc_o && k < 50) begin tick(); k++; end
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL mreset_cyc cyc=%b want 1 before reset", wb_cyc_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mreset_async cyc=%b stb=%b busy=%b want 0/0/0 before next edge",
               wb_cyc_o, wb_stb_o, busy);
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt != 0 || pix_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mreset_after done=%0d ready=%b busy=%b want 0/0/0", done_cnt, pix_ready, busy);
    end
    load_random(8);
    test_transfer("after_reset", 32'h0000_0600, 2, 2, 1'b0);
  endtask

  task automatic test_random();
    int n;
    logic [31:0] b;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 10);
      b = $urandom;
      if (it % 3 == 0) b = 32'hFFFF_FFE0 | (b & 32'h1F);
      load_random(4 * n + $urandom_range(0, 5));
      dense = ($urandom_range(0, 1) == 1);
      test_transfer("random", b, n, $urandom_range(0, 3), (it % 2) == 1);
    end
    dense = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
